// File: rtl/bcd_to_bin.sv
// Four-digit BCD to 14-bit binary converter using a sequential reverse double-dabble.
// One request takes 14 shift cycles; digits above 9 are flagged without shifting.
module bcd_to_bin (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        START,
    input  logic [3:0]  D0,
    input  logic [3:0]  D1,
    input  logic [3:0]  D2,
    input  logic [3:0]  D3,
    output logic [13:0] BIN,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    typedef enum logic [1:0] {StIdle, StShift, StFin} state_e;

    state_e      state_q, state_d;
    logic [15:0] bcd_q, bcd_d;
    logic [13:0] sr_q, sr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [13:0] bin_q, bin_d;
    logic        err_q, err_d;

    logic [29:0] shifted;
    logic [15:0] bcd_fix;
    logic [3:0]  dig;
    logic        bad_digit;

    always_comb begin
        shifted = {bcd_q, sr_q} >> 1;
        bcd_fix = '0;
        dig     = '0;
        // Correct each digit after the shift, not before, so the result lands in sr.
        for (int i = 0; i < 4; i++) begin
            dig = shifted[14 + 4 * i +: 4];
            bcd_fix[4 * i +: 4] = dig[3] ? (dig - 4'd3) : dig;
        end
        bad_digit = (D0 > 4'd9) | (D1 > 4'd9) | (D2 > 4'd9) | (D3 > 4'd9);
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (START) begin
                    bcd_d = {D3, D2, D1, D0};
                    sr_d  = '0;
                    cnt_d = '0;
                    if (bad_digit) begin
                        err_d   = 1'b1;
                        bin_d   = '0;
                        state_d = StFin;
                    end else begin
                        err_d   = 1'b0;
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                bcd_d = bcd_fix;
                sr_d  = shifted[13:0];
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd13) begin
                    bin_d   = shifted[13:0];
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= StIdle;
            bcd_q   <= '0;
            sr_q    <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
        end
    end

    // Result register updates only on entry to FIN, hiding intermediate shifts.
    assign BIN  = bin_q;
    assign ERR  = err_q;
    assign BUSY = (state_q == StShift);
    assign DONE = (state_q == StFin);

endmodule
